// File: rtl/idct_block_scheduler.sv
// Frame sequencer for the pre-IDCT block path: walks Y then stacked U/V 8x8 blocks,
// overlapping Fetch of block k+1 with compute/write-back of block k on ping-pong banks.
module idct_block_scheduler #(
    parameter int Y_COLS  = 40,
    parameter int Y_ROWS  = 30,
    parameter int UV_COLS = 20,
    parameter int UV_ROWS = 60
) (
    input  logic       Clock_50,
    input  logic       Reset,
    input  logic       start,
    output logic       fetch_start,
    input  logic       fetch_finish,
    output logic [8:0] fetch_CA_init,
    output logic [8:0] fetch_RA_init,
    output logic       fetch_Y_finished,
    output logic       compute_start,
    input  logic       compute_finish,
    output logic [8:0] compute_CA_init,
    output logic [8:0] compute_RA_init,
    output logic       compute_Y_finished,
    output logic       bank_sel,
    output logic       busy,
    output logic       done
);

    localparam int          TOTAL_BLOCKS = Y_COLS * Y_ROWS + UV_COLS * UV_ROWS;
    localparam logic [11:0] TOTAL_W      = 12'(TOTAL_BLOCKS);
    localparam logic [5:0]  Y_COL_LAST   = 6'(Y_COLS - 1);
    localparam logic [5:0]  Y_ROW_LAST   = 6'(Y_ROWS - 1);
    localparam logic [5:0]  UV_COL_LAST  = 6'(UV_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEADIN_START,
        S_LEADIN_WAIT,
        S_COMMON_START,
        S_COMMON_WAIT,
        S_LEADOUT_START,
        S_LEADOUT_WAIT,
        S_DONE
    } state_t;

    state_t      state_q;

    // Pointer to the next block to be fetched, plus the count of fetches issued.
    logic [5:0]  fcol_q, fcol_d;
    logic [5:0]  frow_q, frow_d;
    logic        freg_q, freg_d;
    logic [11:0] fetched_q;

    // *_out_q: a start is outstanding; *_fin_q: its finish has been seen.
    logic        f_out_q, f_fin_q;
    logic        c_out_q, c_fin_q;

    logic        fetch_start_q, compute_start_q;
    logic [8:0]  fetch_ca_q, fetch_ra_q;
    logic        fetch_reg_q;
    logic [8:0]  compute_ca_q, compute_ra_q;
    logic        compute_reg_q;
    logic        bank_sel_q, busy_q, done_q;

    logic        f_done, c_done, last_fetched;
    logic        issue_fetch, issue_compute, advance;

    always_comb begin
        fcol_d = fcol_q;
        frow_d = frow_q;
        freg_d = freg_q;
        if (!freg_q) begin
            if (fcol_q == Y_COL_LAST) begin
                fcol_d = 6'd0;
                if (frow_q == Y_ROW_LAST) begin
                    frow_d = 6'd0;
                    freg_d = 1'b1;
                end else begin
                    frow_d = frow_q + 6'd1;
                end
            end else begin
                fcol_d = fcol_q + 6'd1;
            end
        end else begin
            if (fcol_q == UV_COL_LAST) begin
                fcol_d = 6'd0;
                frow_d = frow_q + 6'd1;
            end else begin
                fcol_d = fcol_q + 6'd1;
            end
        end
    end

    // A finish pulse arriving in the wait cycle counts immediately, saving a cycle.
    always_comb begin
        f_done        = f_fin_q | (fetch_finish & f_out_q);
        c_done        = c_fin_q | (compute_finish & c_out_q);
        last_fetched  = (fetched_q == TOTAL_W);
        issue_fetch   = 1'b0;
        issue_compute = 1'b0;
        advance       = 1'b0;
        case (state_q)
            S_IDLE: begin
                issue_fetch = start;
            end
            S_LEADIN_WAIT: begin
                if (f_done) begin
                    advance       = 1'b1;
                    issue_compute = 1'b1;
                    issue_fetch   = !last_fetched;
                end
            end
            S_COMMON_WAIT: begin
                if (f_done && c_done) begin
                    advance       = 1'b1;
                    issue_compute = 1'b1;
                    issue_fetch   = !last_fetched;
                end
            end
            default: begin
                issue_fetch = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock_50 or posedge Reset) begin
        if (Reset) begin
            state_q         <= S_IDLE;
            fcol_q          <= 6'd0;
            frow_q          <= 6'd0;
            freg_q          <= 1'b0;
            fetched_q       <= 12'd0;
            f_out_q         <= 1'b0;
            f_fin_q         <= 1'b0;
            c_out_q         <= 1'b0;
            c_fin_q         <= 1'b0;
            fetch_start_q   <= 1'b0;
            compute_start_q <= 1'b0;
            fetch_ca_q      <= 9'd0;
            fetch_ra_q      <= 9'd0;
            fetch_reg_q     <= 1'b0;
            compute_ca_q    <= 9'd0;
            compute_ra_q    <= 9'd0;
            compute_reg_q   <= 1'b0;
            bank_sel_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            fetch_start_q   <= issue_fetch;
            compute_start_q <= issue_compute;
            done_q          <= 1'b0;

            if (fetch_finish && f_out_q) begin
                f_fin_q <= 1'b1;
                f_out_q <= 1'b0;
            end
            if (compute_finish && c_out_q) begin
                c_fin_q <= 1'b1;
                c_out_q <= 1'b0;
            end

            if (issue_fetch) begin
                fetch_ca_q  <= {fcol_q, 3'b000};
                fetch_ra_q  <= {frow_q, 3'b000};
                fetch_reg_q <= freg_q;
                fcol_q      <= fcol_d;
                frow_q      <= frow_d;
                freg_q      <= freg_d;
                fetched_q   <= fetched_q + 12'd1;
                f_out_q     <= 1'b1;
            end
            if (issue_compute) begin
                c_out_q <= 1'b1;
            end
            if (advance) begin
                bank_sel_q    <= ~bank_sel_q;
                compute_ca_q  <= fetch_ca_q;
                compute_ra_q  <= fetch_ra_q;
                compute_reg_q <= fetch_reg_q;
            end

            // Neither stage can answer in the cycle its start is high, so the
            // latch clears in the start cycles below never drop a real finish.
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= S_LEADIN_START;
                    end
                end
                S_LEADIN_START: begin
                    f_fin_q <= 1'b0;
                    state_q <= S_LEADIN_WAIT;
                end
                S_LEADIN_WAIT: begin
                    if (f_done) begin
                        state_q <= last_fetched ? S_LEADOUT_START : S_COMMON_START;
                    end
                end
                S_COMMON_START: begin
                    f_fin_q <= 1'b0;
                    c_fin_q <= 1'b0;
                    state_q <= S_COMMON_WAIT;
                end
                S_COMMON_WAIT: begin
                    if (f_done && c_done) begin
                        state_q <= last_fetched ? S_LEADOUT_START : S_COMMON_START;
                    end
                end
                S_LEADOUT_START: begin
                    c_fin_q <= 1'b0;
                    state_q <= S_LEADOUT_WAIT;
                end
                S_LEADOUT_WAIT: begin
                    if (c_done) begin
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        fcol_q    <= 6'd0;
                        frow_q    <= 6'd0;
                        freg_q    <= 1'b0;
                        fetched_q <= 12'd0;
                        f_out_q   <= 1'b0;
                        f_fin_q   <= 1'b0;
                        c_out_q   <= 1'b0;
                        c_fin_q   <= 1'b0;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fetch_start        = fetch_start_q;
    assign fetch_CA_init      = fetch_ca_q;
    assign fetch_RA_init      = fetch_ra_q;
    assign fetch_Y_finished   = fetch_reg_q;
    assign compute_start      = compute_start_q;
    assign compute_CA_init    = compute_ca_q;
    assign compute_RA_init    = compute_ra_q;
    assign compute_Y_finished = compute_reg_q;
    assign bank_sel           = bank_sel_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: doc/idct_block_scheduler.md
Name: idct_block_scheduler

Overview:
- Top-level sequencer for the milestone-2 decode path.
- Walks every 8x8 pre-IDCT block in raster order: first the Y plane (320x240), then the combined U/V chroma region (160 wide x 480 rows).
- Drives the Fetch block (start, CA_init, RA_init, Y_finished) and the compute/write-back block, using a lead-in / common / lead-out overlap schedule.
- Ping-pongs the DP-RAM bank between the two stages.

Parameters:
- Y_COLS, 40, Y-plane blocks per row
- Y_ROWS, 30, Y-plane block rows
- UV_COLS, 20, chroma blocks per row
- UV_ROWS, 60, chroma block rows (U then V stacked)

Ports:
- Clock_50  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a full-frame decode
- fetch_start  out  1  one-cycle pulse to Fetch
- fetch_finish  in  1  one-cycle pulse from Fetch
- fetch_CA_init  out  9  column pixel origin of the fetched block (col*8)
- fetch_RA_init  out  9  row pixel origin of the fetched block (row*8)
- fetch_Y_finished  out  1  0 = Y region, 1 = chroma region, for the fetched block
- compute_start  out  1  one-cycle pulse to compute/write-back
- compute_finish  in  1  one-cycle pulse from compute/write-back
- compute_CA_init  out  9  column origin of the block being computed
- compute_RA_init  out  9  row origin of the block being computed
- compute_Y_finished  out  1  region flag of the block being computed
- bank_sel  out  1  DP-RAM bank Fetch writes; compute uses ~bank_sel
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when the last block is written

Behaviour:
Reset:
- All outputs 0; state S_IDLE; block pointers 0; finish latches cleared.
- Reset asserted mid-frame aborts immediately. No resume; a fresh start is required.

Block pointer (fcol, frow, freg):
- Advances on each fetch_start.
- fcol increments. At the wrap value (Y_COLS-1 in Y, UV_COLS-1 in chroma), fcol goes to 0 and frow increments.
- At the last Y block (frow=Y_ROWS-1, fcol=Y_COLS-1): next pointer is (0,0), freg=1.
- Last block of the frame: freg=1, frow=UV_ROWS-1, fcol=UV_COLS-1. Total 2400 blocks; block index counter is 12 bits.
- fetch_CA_init = fcol<<3 and fetch_RA_init = frow<<3, each 9 bits. Maximum values are 312 and 472; no truncation.
- fetch_* outputs are registered and stable from the fetch_start cycle until the next fetch_start.

States:
- S_IDLE: on start go to S_LEADIN_START; busy<=1. start is ignored in every other state.
- S_LEADIN_START: fetch_start=1 for 1 cycle (block 0, bank_sel=0); go to S_LEADIN_WAIT.
- S_LEADIN_WAIT: wait for latched fetch_finish.
  - Then toggle bank_sel.
  - Copy the fetched block's coords/region to compute_*.
  - Go to S_COMMON_START, or to S_LEADOUT_START if the total is 1 block.
- S_COMMON_START: fetch_start=1 and compute_start=1 in the same cycle; go to S_COMMON_WAIT.
- S_COMMON_WAIT: wait until both finish latches are set. The finishes may arrive in the same cycle or in either order.
  - Then toggle bank_sel and copy fetch coords to compute_*.
  - If the block just fetched was the last one, go to S_LEADOUT_START; else go to S_COMMON_START.
- S_LEADOUT_START: compute_start=1 only; go to S_LEADOUT_WAIT.
- S_LEADOUT_WAIT: on latched compute_finish go to S_DONE.
- S_DONE: done=1 for 1 cycle; busy<=0; pointers cleared; go to S_IDLE.

Finish latches:
- Set on the *_finish pulse; cleared in any *_START state.
- A finish pulse in S_IDLE or S_DONE is ignored.
- A finish with no matching outstanding start is ignored. This covers a compute_finish during the lead-in.

Latency and sequencing:
- Start pulses are issued one cycle after the wait condition is satisfied, never back-to-back.
- Fetch has already returned to its idle state when its next start arrives.
- Megastate count is N+1 for N blocks.

Test Plan:
- Reset=1 mid-S_COMMON_WAIT -> all outputs 0 the same cycle. After release plus start, fetch_start shows CA_init=0, RA_init=0, Y_finished=0.
- start with finish models that respond 10 cycles after each start -> first fetch_start has (0,0,0). The next fetch_start (with the first compute_start) has CA_init=8, compute_CA_init=0. bank_sel toggles 0->1.
- Walk the Y/chroma boundary -> fetch #1199 gives CA_init=312, RA_init=232, Y_finished=0. Fetch #1200 gives (0,0,1); compute_Y_finished turns 1 one megastate later.
- fetch_finish and compute_finish in the same cycle, then fetch 5 cycles after compute in the next megastate -> both advance correctly with no lost finish. Each start pulse is exactly 1 cycle wide.
- Full frame -> exactly 2400 fetch_start and 2400 compute_start pulses. Last fetch has CA=152, RA=472, Y_finished=1. done pulses once; busy falls with done. start pulses asserted while busy are ignored.
- Parameter override Y_COLS=Y_ROWS=UV_COLS=UV_ROWS=1 -> sequence: lead-in, one common, lead-out, done. The same run also checks that a spurious compute_finish during the lead-in is ignored.
